axi_mst: RTL and testbench



---
 rtl/axi_mst_if.sv | 85 ++++++++
 rtl/axi_mst.sv | 207 ++++++++++++++++++++
 tb/tb_axi_mst.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_mst_if.sv
// AXI4 master-side bus bundle used between axi_mst and the system interconnect.
// Only the fields the bridge drives or consumes are carried.
interface axi_mst_if #(
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 64,
  parameter int ID_BITS   = 5,
  parameter int USER_BITS = 1
);
  localparam int STRB_BITS = DATA_BITS / 8;

  logic                 aw_valid;
  logic                 aw_ready;
  logic [ADDR_BITS-1:0] aw_addr;
  logic [7:0]           aw_len;
  logic [2:0]           aw_size;
  logic [1:0]           aw_burst;
  logic                 aw_lock;
  logic [3:0]           aw_cache;
  logic [2:0]           aw_prot;
  logic [3:0]           aw_qos;
  logic [3:0]           aw_region;
  logic [ID_BITS-1:0]   aw_id;
  logic [USER_BITS-1:0] aw_user;

  logic                 w_valid;
  logic                 w_ready;
  logic [DATA_BITS-1:0] w_data;
  logic [STRB_BITS-1:0] w_strb;
  logic                 w_last;
  logic [USER_BITS-1:0] w_user;

  logic                 b_valid;
  logic                 b_ready;
  logic [1:0]           b_resp;

  logic                 ar_valid;
  logic                 ar_ready;
  logic [ADDR_BITS-1:0] ar_addr;
  logic [7:0]           ar_len;
  logic [2:0]           ar_size;
  logic [1:0]           ar_burst;
  logic                 ar_lock;
  logic [3:0]           ar_cache;
  logic [2:0]           ar_prot;
  logic [3:0]           ar_qos;
  logic [3:0]           ar_region;
  logic [ID_BITS-1:0]   ar_id;
  logic [USER_BITS-1:0] ar_user;

  logic                 r_valid;
  logic                 r_ready;
  logic [DATA_BITS-1:0] r_data;
  logic [1:0]           r_resp;
  logic                 r_last;

  modport master (
    output aw_valid, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
           aw_prot, aw_qos, aw_region, aw_id, aw_user,
    input  aw_ready,
    output w_valid, w_data, w_strb, w_last, w_user,
    input  w_ready,
    input  b_valid, b_resp,
    output b_ready,
    output ar_valid, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
           ar_prot, ar_qos, ar_region, ar_id, ar_user,
    input  ar_ready,
    input  r_valid, r_data, r_resp, r_last,
    output r_ready
  );

  modport slave (
    input  aw_valid, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
           aw_prot, aw_qos, aw_region, aw_id, aw_user,
    output aw_ready,
    input  w_valid, w_data, w_strb, w_last, w_user,
    output w_ready,
    output b_valid, b_resp,
    input  b_ready,
    input  ar_valid, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
           ar_prot, ar_qos, ar_region, ar_id, ar_user,
    output ar_ready,
    output r_valid, r_data, r_resp, r_last,
    input  r_ready
  );
endinterface

// File: rtl/axi_mst.sv
// Req/resp to AXI4 master bridge: one transaction in flight, INCR bursts of 1..256 beats,
// registered AXI valids and a single-entry response buffer.
module axi_mst #(
  parameter logic [4:0] req_id                = '0,
  parameter logic [0:0] req_user              = '0,
  parameter int         CFG_SYSBUS_ADDR_BITS  = 32,
  parameter int         CFG_SYSBUS_DATA_BITS  = 64,
  parameter int         CFG_SYSBUS_DATA_BYTES = CFG_SYSBUS_DATA_BITS / 8
) (
  input  logic                             i_clk,
  input  logic                             i_nrst,
  axi_mst_if.master                        xmst,
  input  logic                             i_req_valid,
  output logic                             o_req_ready,
  input  logic [CFG_SYSBUS_ADDR_BITS-1:0]  i_req_addr,
  input  logic                             i_req_write,
  input  logic [7:0]                       i_req_len,
  input  logic [2:0]                       i_req_size,
  input  logic [CFG_SYSBUS_DATA_BITS-1:0]  i_req_wdata,
  input  logic [CFG_SYSBUS_DATA_BYTES-1:0] i_req_wstrb,
  output logic                             o_resp_valid,
  output logic [CFG_SYSBUS_DATA_BITS-1:0]  o_resp_rdata,
  output logic                             o_resp_err,
  output logic                             o_resp_last,
  input  logic                             i_resp_ready
);
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ADDR_R = 3'd1;
  localparam logic [2:0] ST_DATA_R = 3'd2;
  localparam logic [2:0] ST_ADDR_W = 3'd3;
  localparam logic [2:0] ST_DATA_W = 3'd4;
  localparam logic [2:0] ST_WAIT_B = 3'd5;
  localparam logic [2:0] ST_RESP   = 3'd6;

  logic [2:0]                       state;
  logic [CFG_SYSBUS_ADDR_BITS-1:0]  addr;
  logic [7:0]                       len;
  logic [2:0]                       size;
  logic [CFG_SYSBUS_DATA_BITS-1:0]  wdata;
  logic [CFG_SYSBUS_DATA_BYTES-1:0] wstrb;
  logic [7:0]                       beat_cnt;
  logic                             err;
  logic                             ar_valid;
  logic                             aw_valid;
  logic                             w_valid;
  logic                             aw_done;
  logic                             resp_valid;
  logic [CFG_SYSBUS_DATA_BITS-1:0]  rdata;
  logic                             last;

  logic r_ready, b_ready, w_last;
  logic ar_hs, aw_hs, w_hs, r_hs, req_acc;
  logic unused_resp_bits;

  assign w_last  = (beat_cnt == len);
  // Readiness toward both sides is forced low while reset is asserted.
  assign r_ready = i_nrst & (state == ST_DATA_R) & (~resp_valid | i_resp_ready);
  assign b_ready = i_nrst & (state == ST_WAIT_B);
  assign ar_hs   = ar_valid & xmst.ar_ready;
  assign aw_hs   = aw_valid & xmst.aw_ready;
  assign w_hs    = w_valid & xmst.w_ready;
  assign r_hs    = xmst.r_valid & r_ready;
  assign req_acc = i_req_valid & o_req_ready;
  assign unused_resp_bits = xmst.r_resp[0] ^ xmst.b_resp[0];

  always_comb begin
    o_req_ready = 1'b0;
    if (i_nrst) begin
      case (state)
        ST_IDLE:   o_req_ready = ~resp_valid;
        ST_DATA_W: o_req_ready = ~w_valid;
        default:   o_req_ready = 1'b0;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      state      <= ST_IDLE;
      addr       <= '0;
      len        <= '0;
      size       <= '0;
      wdata      <= '0;
      wstrb      <= '0;
      beat_cnt   <= '0;
      err        <= 1'b0;
      ar_valid   <= 1'b0;
      aw_valid   <= 1'b0;
      w_valid    <= 1'b0;
      aw_done    <= 1'b0;
      resp_valid <= 1'b0;
      rdata      <= '0;
      last       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (req_acc) begin
          addr     <= i_req_addr;
          len      <= i_req_len;
          size     <= i_req_size;
          wdata    <= i_req_wdata;
          wstrb    <= i_req_wstrb;
          beat_cnt <= '0;
          err      <= 1'b0;
          aw_done  <= 1'b0;
          if (i_req_write) begin
            aw_valid <= 1'b1;
            w_valid  <= 1'b1;
            state    <= ST_ADDR_W;
          end else begin
            ar_valid <= 1'b1;
            state    <= ST_ADDR_R;
          end
        end
        ST_ADDR_R: if (ar_hs) begin
          ar_valid <= 1'b0;
          state    <= ST_DATA_R;
        end
        ST_DATA_R: begin
          if (r_hs) begin
            resp_valid <= 1'b1;
            rdata      <= xmst.r_data;
            err        <= xmst.r_resp[1];
            last       <= xmst.r_last;
            if (xmst.r_last) state <= ST_RESP;
          end else if (i_resp_ready) begin
            resp_valid <= 1'b0;
          end
        end
        ST_ADDR_W: begin
          if (aw_hs) begin
            aw_valid <= 1'b0;
            aw_done  <= 1'b1;
          end
          if (w_hs) begin
            w_valid  <= 1'b0;
            beat_cnt <= beat_cnt + 8'd1;
          end
          // First beat is done once beat_cnt has left zero or is handshaking now.
          if ((aw_done | aw_hs) & ((beat_cnt != 8'd0) | w_hs))
            state <= (len == 8'd0) ? ST_WAIT_B : ST_DATA_W;
        end
        ST_DATA_W: begin
          if (req_acc) begin
            wdata   <= i_req_wdata;
            wstrb   <= i_req_wstrb;
            w_valid <= 1'b1;
          end
          if (w_hs) begin
            w_valid  <= 1'b0;
            beat_cnt <= beat_cnt + 8'd1;
            if (w_last) state <= ST_WAIT_B;
          end
        end
        ST_WAIT_B: if (xmst.b_valid) begin
          err        <= xmst.b_resp[1];
          resp_valid <= 1'b1;
          last       <= 1'b1;
          rdata      <= '0;
          state      <= ST_RESP;
        end
        ST_RESP: if (i_resp_ready) begin
          resp_valid <= 1'b0;
          last       <= 1'b0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign xmst.aw_valid  = aw_valid;
  assign xmst.aw_addr   = addr;
  assign xmst.aw_len    = len;
  assign xmst.aw_size   = size;
  assign xmst.aw_burst  = 2'b01;
  assign xmst.aw_lock   = 1'b0;
  assign xmst.aw_cache  = '0;
  assign xmst.aw_prot   = '0;
  assign xmst.aw_qos    = '0;
  assign xmst.aw_region = '0;
  assign xmst.aw_id     = req_id;
  assign xmst.aw_user   = req_user;
  assign xmst.w_valid   = w_valid;
  assign xmst.w_data    = wdata;
  assign xmst.w_strb    = wstrb;
  assign xmst.w_last    = w_last;
  assign xmst.w_user    = req_user;
  assign xmst.b_ready   = b_ready;
  assign xmst.ar_valid  = ar_valid;
  assign xmst.ar_addr   = addr;
  assign xmst.ar_len    = len;
  assign xmst.ar_size   = size;
  assign xmst.ar_burst  = 2'b01;
  assign xmst.ar_lock   = 1'b0;
  assign xmst.ar_cache  = '0;
  assign xmst.ar_prot   = '0;
  assign xmst.ar_qos    = '0;
  assign xmst.ar_region = '0;
  assign xmst.ar_id     = req_id;
  assign xmst.ar_user   = req_user;
  assign xmst.r_ready   = r_ready;

  assign o_resp_valid = resp_valid;
  assign o_resp_rdata = rdata;
  assign o_resp_err   = err;
  assign o_resp_last  = last;
endmodule

// File: tb/tb_axi_mst.sv
// Directed bench for axi_mst: the AXI slave side is scripted cycle by cycle from one
// initial block; expected values are fixed constants or small bench-side counters.
module tb_axi_mst;
  logic        clk = 1'b0;
  logic        nrst;
  logic        req_valid, req_write, resp_ready;
  logic        req_ready, resp_valid, resp_err, resp_last;
  logic [31:0] req_addr;
  logic [7:0]  req_len, req_wstrb;
  logic [2:0]  req_size;
  logic [63:0] req_wdata, resp_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  axi_mst_if bus ();

  axi_mst #(.req_id(5'd0), .req_user(1'b0)) dut (
    .i_clk(clk), .i_nrst(nrst), .xmst(bus),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_addr(req_addr),
    .i_req_write(req_write), .i_req_len(req_len), .i_req_size(req_size),
    .i_req_wdata(req_wdata), .i_req_wstrb(req_wstrb),
    .o_resp_valid(resp_valid), .o_resp_rdata(resp_rdata), .o_resp_err(resp_err),
    .o_resp_last(resp_last), .i_resp_ready(resp_ready)
  );

  function automatic logic [63:0] wd(input int k);
    return 64'hA5A5_0000_0000_0000 | 64'(k);
  endfunction

  function automatic logic [7:0] ws(input int k);
    return 8'h01 << (k % 8);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic wr, input logic [31:0] a, input logic [7:0] l,
                       input logic [2:0] s, input logic [63:0] d, input logic [7:0] st);
    int n = 0;
    req_write = wr; req_addr = a; req_len = l; req_size = s;
    req_wdata = d; req_wstrb = st; req_valid = 1'b1;
    #1;
    while (!req_ready && n < 20) begin cyc(); n++; end
    chk("req_accept", req_ready, 1'b1);
    cyc();
    req_valid = 1'b0;
  endtask

  task automatic ar_phase(input logic [31:0] a, input logic [7:0] l);
    int n = 0;
    while (!bus.ar_valid && n < 20) begin cyc(); n++; end
    chk("ar_valid_up", bus.ar_valid, 1'b1);
    chk("ar_addr", bus.ar_addr, a);
    chk("ar_len", bus.ar_len, l);
    bus.ar_ready = 1'b1;
    cyc();
    bus.ar_ready = 1'b0;
    chk("ar_valid_down", bus.ar_valid, 1'b0);
  endtask

  // Slave streams n beats back-to-back; consumer readiness follows pat (then 1).
  task automatic read_beats(input int n, input logic [15:0] pat, input int err_beat,
                            input logic [63:0] base, output bit saw_drop);
    int  sent = 0, got = 0, t = 0;
    bit  full = 0, cons, hs;
    saw_drop = 0;
    while (got < n && t < 60) begin
      resp_ready  = (t < 16) ? pat[t] : 1'b1;
      bus.r_valid = (sent < n);
      bus.r_data  = base + 64'(sent);
      bus.r_last  = (sent == n - 1);
      bus.r_resp  = (sent == err_beat) ? 2'b11 : 2'b00;
      #1;
      chk("resp_valid_buf", resp_valid, full);
      if (sent < n) begin
        chk("r_ready", bus.r_ready, !full || resp_ready);
        if (!bus.r_ready) saw_drop = 1;
      end
      cons = full && resp_ready;
      if (cons) begin
        chk("rd_data", resp_rdata, base + 64'(got));
        chk("rd_last", resp_last, got == n - 1);
        chk("rd_err", resp_err, got == err_beat);
        got++;
      end
      hs = bus.r_valid && bus.r_ready;
      if (hs) begin sent++; full = 1; end
      else if (cons) full = 0;
      cyc();
      t++;
    end
    bus.r_valid = 1'b0; bus.r_last = 1'b0; resp_ready = 1'b0;
    chk("rd_beats", got, n);
  endtask

  initial begin
    int fed, hs, aws, t;
    bit drop;
    logic [15:0] wpat, vpat;

    nrst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
    req_size = '0; req_wdata = '0; req_wstrb = '0; resp_ready = 1'b0;
    bus.aw_ready = 1'b0; bus.w_ready = 1'b0; bus.b_valid = 1'b0; bus.b_resp = 2'b00;
    bus.ar_ready = 1'b0; bus.r_valid = 1'b0; bus.r_data = '0; bus.r_resp = 2'b00;
    bus.r_last = 1'b0;

    // Reset state
    cyc(); cyc();
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_ar_valid", bus.ar_valid, 1'b0);
    chk("rst_aw_valid", bus.aw_valid, 1'b0);
    chk("rst_w_valid", bus.w_valid, 1'b0);
    chk("rst_r_ready", bus.r_ready, 1'b0);
    chk("rst_b_ready", bus.b_ready, 1'b0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    nrst = 1'b1;
    #1;
    chk("idle_req_ready", req_ready, 1'b1);
    cyc();

    // Single read, ar_ready two cycles after ar_valid
    issue(1'b0, 32'h1000, 8'd0, 3'd3, '0, '0);
    chk("s1_ar_valid", bus.ar_valid, 1'b1);
    chk("s1_ar_addr", bus.ar_addr, 32'h1000);
    chk("s1_ar_len", bus.ar_len, 8'd0);
    chk("s1_ar_size", bus.ar_size, 3'd3);
    chk("s1_ar_burst", bus.ar_burst, 2'b01);
    chk("s1_ar_prot", bus.ar_prot, 3'd0);
    cyc();
    chk("s1_ar_hold1", bus.ar_valid, 1'b1);
    cyc();
    chk("s1_ar_hold2", bus.ar_valid, 1'b1);
    bus.ar_ready = 1'b1;
    cyc();
    bus.ar_ready = 1'b0;
    chk("s1_ar_drop", bus.ar_valid, 1'b0);
    read_beats(1, 16'hFFFF, 99, 64'hDEADBEEF_01234567, drop);
    cyc();

    // Read burst with consumer backpressure 1,0,1,1,0,1
    issue(1'b0, 32'h1100, 8'd3, 3'd3, '0, '0);
    ar_phase(32'h1100, 8'd3);
    read_beats(4, 16'hFFED, 99, 64'h1000_0000_0000_0000, drop);
    chk("s2_r_ready_dropped", drop, 1'b1);
    cyc();

    // Single write, w accepted 3 cycles ahead of aw
    issue(1'b1, 32'h2008, 8'd0, 3'd0, 64'h55, 8'h01);
    chk("s3_aw_valid", bus.aw_valid, 1'b1);
    chk("s3_w_valid", bus.w_valid, 1'b1);
    chk("s3_w_last", bus.w_last, 1'b1);
    chk("s3_aw_addr", bus.aw_addr, 32'h2008);
    chk("s3_w_data", bus.w_data, 64'h55);
    chk("s3_w_strb", bus.w_strb, 8'h01);
    bus.w_ready = 1'b1;
    cyc();
    bus.w_ready = 1'b0;
    chk("s3_w_done", bus.w_valid, 1'b0);
    repeat (2) begin
      chk("s3_aw_hold", bus.aw_valid, 1'b1);
      chk("s3_no_b_ready", bus.b_ready, 1'b0);
      cyc();
    end
    bus.aw_ready = 1'b1;
    cyc();
    bus.aw_ready = 1'b0;
    chk("s3_aw_done", bus.aw_valid, 1'b0);
    chk("s3_b_ready", bus.b_ready, 1'b1);
    bus.b_valid = 1'b1; bus.b_resp = 2'b00;
    cyc();
    bus.b_valid = 1'b0;
    chk("s3_b_ready_off", bus.b_ready, 1'b0);
    chk("s3_resp_valid", resp_valid, 1'b1);
    chk("s3_resp_err", resp_err, 1'b0);
    chk("s3_resp_last", resp_last, 1'b1);
    chk("s3_resp_rdata", resp_rdata, 64'h0);
    resp_ready = 1'b1;
    cyc();
    resp_ready = 1'b0;
    chk("s3_drained", resp_valid, 1'b0);
    cyc();

    // Write burst len=7 with req gaps and w_ready stalls, SLVERR on B
    issue(1'b1, 32'h3000, 8'd7, 3'd3, wd(0), ws(0));
    chk("s4_aw_addr", bus.aw_addr, 32'h3000);
    chk("s4_aw_len", bus.aw_len, 8'd7);
    wpat = 16'b1011_0110_1101_1011;
    vpat = 16'b1101_1011_0111_0110;
    fed = 1; hs = 0; aws = 0; t = 0;
    while (!bus.b_ready && t < 100) begin
      bus.w_ready  = wpat[t % 16];
      bus.aw_ready = (t >= 2);
      req_valid    = (fed < 8) && vpat[t % 16];
      req_wdata    = wd(fed);
      req_wstrb    = ws(fed);
      #1;
      if (bus.w_valid && bus.w_ready) begin
        chk("s4_w_data", bus.w_data, wd(hs));
        chk("s4_w_strb", bus.w_strb, ws(hs));
        chk("s4_w_last", bus.w_last, hs == 7);
        hs++;
      end
      if (bus.aw_valid && bus.aw_ready) aws++;
      if (req_valid && req_ready) fed++;
      cyc();
      t++;
    end
    req_valid = 1'b0; bus.w_ready = 1'b0; bus.aw_ready = 1'b0;
    chk("s4_w_count", hs, 8);
    chk("s4_aw_count", aws, 1);
    chk("s4_fed", fed, 8);
    chk("s4_b_ready", bus.b_ready, 1'b1);
    bus.b_valid = 1'b1; bus.b_resp = 2'b10;
    cyc();
    bus.b_valid = 1'b0; bus.b_resp = 2'b00;
    chk("s4_resp_valid", resp_valid, 1'b1);
    chk("s4_resp_err", resp_err, 1'b1);
    chk("s4_resp_last", resp_last, 1'b1);
    resp_ready = 1'b1;
    cyc();
    resp_ready = 1'b0;
    chk("s4_drained", resp_valid, 1'b0);
    cyc();

    // Read error on beat 2 of 3 only
    issue(1'b0, 32'h4400, 8'd2, 3'd3, '0, '0);
    ar_phase(32'h4400, 8'd2);
    read_beats(3, 16'hFFFF, 1, 64'h2000_0000_0000_0000, drop);
    cyc();

    // Reset during write burst after three beats
    issue(1'b1, 32'h4000, 8'd7, 3'd3, wd(0), ws(0));
    fed = 1; hs = 0; t = 0;
    bus.w_ready = 1'b1; bus.aw_ready = 1'b1;
    while (hs < 3 && t < 30) begin
      req_valid = (fed < 8);
      req_wdata = wd(fed);
      req_wstrb = ws(fed);
      #1;
      if (bus.w_valid && bus.w_ready) hs++;
      if (req_valid && req_ready) fed++;
      cyc();
      t++;
    end
    chk("s6_pre_beats", hs, 3);
    nrst = 1'b0; req_valid = 1'b0; bus.w_ready = 1'b0; bus.aw_ready = 1'b0;
    #1;
    chk("s6_rst_req_ready", req_ready, 1'b0);
    chk("s6_rst_b_ready", bus.b_ready, 1'b0);
    cyc();
    chk("s6_aw_valid", bus.aw_valid, 1'b0);
    chk("s6_w_valid", bus.w_valid, 1'b0);
    chk("s6_ar_valid", bus.ar_valid, 1'b0);
    chk("s6_r_ready", bus.r_ready, 1'b0);
    chk("s6_b_ready", bus.b_ready, 1'b0);
    chk("s6_resp_valid", resp_valid, 1'b0);
    nrst = 1'b1;
    cyc();
    issue(1'b0, 32'h5000, 8'd0, 3'd3, '0, '0);
    ar_phase(32'h5000, 8'd0);
    read_beats(1, 16'hFFFF, 99, 64'h0BAD_F00D_CAFE_0001, drop);
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
